// File: rtl/aes_ecb_seq_if.sv
// Stream and core-side signal bundle for the ECB sequencer.
//   slave  : the sequencer itself (consumes start/plaintext/core result, drives
//            in_ready, core_run/core_din, ciphertext stream and status)
//   master : the host / core / consumer side
interface aes_ecb_seq_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] num_blocks;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic             core_run;
   logic [127:0]     core_din;
   logic             core_done;
   logic [127:0]     core_dout;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] blk_cnt;

   modport slave (
      input  start, abort, num_blocks, in_valid, in_data, core_done, core_dout, out_ready,
      output in_ready, core_run, core_din, out_valid, out_data, busy, done, error, blk_cnt
   );

   modport master (
      output start, abort, num_blocks, in_valid, in_data, core_done, core_dout, out_ready,
      input  in_ready, core_run, core_din, out_valid, out_data, busy, done, error, blk_cnt
   );
endinterface

// File: rtl/aes_ecb_seq.sv
// Runs a multi-block ECB message through a single aes_enc core, one block at a
// time: fetch plaintext, pulse core_run, wait for core_done under a watchdog,
// then present the ciphertext on the output stream.
// Ports:
//   clk       rising-edge system clock
//   rst       asynchronous active-high reset
//   bus       aes_ecb_seq_if.slave: start/abort/num_blocks control, plaintext
//             stream (in_*), core handshake (core_*), ciphertext stream (out_*),
//             status busy/done/error/blk_cnt
module aes_ecb_seq #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input logic          clk,
   input logic          rst,
   aes_ecb_seq_if.slave bus
);

   localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAUNCH,
      S_WAIT,
      S_EMIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] blk_lim;
   logic [CNT_W-1:0] blk_cnt_q;
   logic [TMR_W-1:0] timer;
   logic [127:0]     din_q;
   logic [127:0]     dout_q;
   logic             done_q;
   logic             error_q;
   logic [CNT_W-1:0] blk_nxt;

   assign blk_nxt = blk_cnt_q + CNT_W'(1);

   // Stream/core strobes are pure decodes of the state register.
   assign bus.in_ready  = (state == S_FETCH);
   assign bus.core_run  = (state == S_LAUNCH);
   assign bus.out_valid = (state == S_EMIT);
   assign bus.busy      = (state != S_IDLE);
   assign bus.core_din  = din_q;
   assign bus.out_data  = dout_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.blk_cnt   = blk_cnt_q;

   // Sequencer FSM with its datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         blk_lim   <= '0;
         blk_cnt_q <= '0;
         timer     <= '0;
         din_q     <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            // Abort drops everything silently; error and blk_cnt keep their values.
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     error_q <= 1'b0;
                     if (bus.num_blocks != '0) begin
                        blk_lim   <= bus.num_blocks;
                        blk_cnt_q <= '0;
                        state     <= S_FETCH;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  if (bus.in_valid) begin
                     din_q <= bus.in_data;
                     state <= S_LAUNCH;
                  end
               end
               S_LAUNCH: begin
                  timer <= '0;
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  timer <= timer + TMR_W'(1);
                  // A completion on the last watchdog cycle still counts as success.
                  if (bus.core_done) begin
                     dout_q <= bus.core_dout;
                     state  <= S_EMIT;
                  end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                     state   <= S_IDLE;
                  end
               end
               S_EMIT: begin
                  if (bus.out_ready) begin
                     blk_cnt_q <= blk_nxt;
                     if (blk_nxt == blk_lim) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
